// File: rtl/puf_response_collector.sv
// ---------------------------------------------------------------------------
// puf_response_collector
//
// Purpose:
//   Drives a one-bit ring-oscillator PUF through a fixed per-bit schedule
//   (CLEAR -> SETTLE -> MEASURE -> HOLD), samples the single response bit
//   after each measurement and packs RESP_BITS of them into a response word.
//   Challenges run seed, seed+1, ... (mod 256). The finished word is offered
//   to the consumer on a valid/ready handshake.
//
// Parameters:
//   RESP_BITS      response bits per run (1..256)
//   SETTLE_CYCLES  cycles with ROs enabled and counters held in reset (>= 1)
//   WINDOW_CYCLES  measurement window length in clk cycles (>= 1)
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-high reset; aborts any run
//   start          begin a run (honoured in IDLE only)
//   seed           base challenge, captured with the accepted start
//   busy           high in every state except IDLE
//   puf_en         PUF ring-oscillator enable
//   puf_reset      PUF counter reset
//   puf_challenge  PUF challenge, bit 0 is the MSB
//   puf_out        PUF response bit
//   resp_data      assembled response word, resp_data[0] answers challenge seed
//   resp_valid     resp_data complete and stable
//   resp_ready     consumer accepts the word
//
// Every output is a flop whose next value is decoded from the next state, so
// outputs change exactly on the edge that enters a state and carry no
// combinational path from inputs.
// ---------------------------------------------------------------------------
module puf_response_collector #(
    parameter int RESP_BITS     = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int WINDOW_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [7:0]           seed,
    output logic                 busy,
    output logic                 puf_en,
    output logic                 puf_reset,
    output logic [0:7]           puf_challenge,
    input  logic                 puf_out,
    output logic [RESP_BITS-1:0] resp_data,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    // One counter serves SETTLE, MEASURE and HOLD; it must reach the larger
    // of the two configurable lengths minus one (HOLD only needs 0..1).
    localparam int CNT_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam int IDX_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WINDOW_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_MEASURE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t               state_q,      state_d;
    logic [CNT_W-1:0]     cnt_q,        cnt_d;
    logic [IDX_W-1:0]     idx_q,        idx_d;
    logic [7:0]           chal_q,       chal_d;
    logic [RESP_BITS-1:0] data_q,       data_d;
    logic                 busy_q,       busy_d;
    logic                 en_q,         en_d;
    logic                 prst_q,       prst_d;
    logic                 valid_q,      valid_d;

    // -----------------------------------------------------------------------
    // Next-state and next-output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        chal_d  = chal_q;
        data_d  = data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The challenge register doubles as the seed latch:
                    // later seed changes cannot reach the run.
                    chal_d  = seed;
                    idx_d   = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MEASURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_MEASURE: begin
                if (cnt_q == WINDOW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    // Comparator has had a full cycle to settle with the
                    // counters frozen; capture the bit now.
                    data_d[idx_q] = puf_out;
                    cnt_d         = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        // seed + b tracked incrementally; 8-bit add wraps.
                        chal_d  = chal_q + 8'd1;
                        state_d = ST_CLEAR;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decoded from the state being entered, then registered.
        busy_d  = (state_d != ST_IDLE);
        en_d    = (state_d == ST_SETTLE) || (state_d == ST_MEASURE);
        prst_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR) ||
                  (state_d == ST_SETTLE) || (state_d == ST_DONE);
        valid_d = (state_d == ST_DONE);
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // value of its neighbours; blocking here would create ordering races.
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            chal_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
            prst_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            chal_q  <= chal_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            en_q    <= en_d;
            prst_q  <= prst_d;
            valid_q <= valid_d;
        end
    end

    assign busy          = busy_q;
    assign puf_en        = en_q;
    assign puf_reset     = prst_q;
    assign puf_challenge = chal_q;   // chal_q[7] lands on puf_challenge[0]
    assign resp_data     = data_q;
    assign resp_valid    = valid_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// ---------------------------------------------------------------------------
// tb_puf_response_collector
//
// Bench for puf_response_collector with a small configuration
// (RESP_BITS=4, SETTLE=2, WINDOW=8, so 13 cycles per bit).
//
// The PUF is modelled as a 256-entry table of response bits indexed by
// challenge. Its comparator only shows the true bit once the counters have
// been frozen (en=0, reset=0) for two cycles; before that it shows the
// complement, so capturing the bit at the wrong moment gives a wrong word.
//
// Stimulus pushes the expected word (table lookups at seed+i mod 256), the
// expected challenge sequence and the start cycle into queues; a monitor
// running on the falling edge pops and compares against DUT activity.
// ---------------------------------------------------------------------------
module tb_puf_response_collector;

    localparam int RB  = 4;
    localparam int S   = 2;
    localparam int W   = 8;
    localparam int P   = S + W + 3;
    localparam int LAT = 1 + RB * P;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    seed;
    logic          busy;
    logic          puf_en;
    logic          puf_reset;
    logic [0:7]    puf_challenge;
    logic          puf_out;
    logic [RB-1:0] resp_data;
    logic          resp_valid;
    logic          resp_ready;

    puf_response_collector #(
        .RESP_BITS    (RB),
        .SETTLE_CYCLES(S),
        .WINDOW_CYCLES(W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .seed         (seed),
        .busy         (busy),
        .puf_en       (puf_en),
        .puf_reset    (puf_reset),
        .puf_challenge(puf_challenge),
        .puf_out      (puf_out),
        .resp_data    (resp_data),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    bit            tbl [256];
    logic [RB-1:0] exp_q   [$];
    logic [7:0]    chal_q  [$];
    int            start_q [$];
    int            checks   = 0;
    int            failures = 0;
    int            hs_cnt   = 0;
    logic [RB-1:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RB-1:0] model_word(input logic [7:0] s);
        logic [RB-1:0] w;
        logic [7:0]    c;
        for (int i = 0; i < RB; i++) begin
            c    = s + 8'(i);
            w[i] = tbl[c];
        end
        return w;
    endfunction

    // ---------------- PUF model ----------------
    int hold_cnt = 0;
    initial puf_out = 1'b0;
    always @(negedge clk) begin
        if (!puf_en && !puf_reset) hold_cnt = hold_cnt + 1;
        else                       hold_cnt = 0;
        puf_out = (hold_cnt >= 2) ? tbl[puf_challenge] : ~tbl[puf_challenge];
    end

    // ---------------- monitor ----------------
    logic          prev_en    = 1'b0;
    logic          prev_prst  = 1'b1;
    logic          prev_valid = 1'b0;
    logic          prev_busy  = 1'b0;
    logic [RB-1:0] prev_data  = '0;
    logic [7:0]    prev_chal  = '0;
    logic [7:0]    cur_chal   = '0;
    int            en_rise_cyc   = 0;
    int            prst_fall_cyc = 0;
    bit            idle_chk      = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            chal_q.delete();
            start_q.delete();
            prev_en    = 1'b0;
            prev_prst  = 1'b1;
            prev_valid = 1'b0;
            prev_busy  = 1'b0;
            idle_chk   = 1'b0;
        end else begin
            if (idle_chk) begin
                check("idle_after_accept_valid", 32'(resp_valid), 32'd0);
                check("idle_after_accept_busy", 32'(busy), 32'd0);
                idle_chk = 1'b0;
            end
            if (busy && !prev_busy) begin
                if (start_q.size() == 0) check("busy_without_start", 32'd1, 32'd0);
                else                     check("busy_rise_latency", 32'(cyc - start_q[0]), 32'd1);
            end
            if (puf_en && !prev_en) begin
                if (chal_q.size() == 0) begin
                    check("unexpected_bit_slot", 32'd1, 32'd0);
                end else begin
                    cur_chal = chal_q.pop_front();
                    check("challenge", 32'(puf_challenge), 32'(cur_chal));
                    check("settle_reset_high", 32'(puf_reset), 32'd1);
                end
                en_rise_cyc = cyc;
            end
            if (!puf_en && prev_en) begin
                check("en_high_len", 32'(cyc - en_rise_cyc), 32'(S + W));
                check("en_falls_into_hold", 32'(puf_reset), 32'd0);
                check("challenge_held", 32'(puf_challenge), 32'(cur_chal));
            end
            if (!puf_reset && prev_prst) prst_fall_cyc = cyc;
            if (puf_reset && !prev_prst) begin
                check("reset_low_len", 32'(cyc - prst_fall_cyc), 32'(W + 2));
                check("en_low_at_reset_rise", 32'(puf_en), 32'd0);
            end
            if (resp_valid && !prev_valid) begin
                if (start_q.size() == 0) check("valid_without_start", 32'd1, 32'd0);
                else                     check("valid_latency", 32'(cyc - start_q[0]), 32'(LAT));
            end
            if (resp_valid && prev_valid) begin
                check("data_stable", 32'(resp_data), 32'(prev_data));
                check("challenge_stable_done", 32'(puf_challenge), 32'(prev_chal));
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'd1, 32'd0);
                end else begin
                    check("resp_word", 32'(resp_data), 32'(exp_q.pop_front()));
                    void'(start_q.pop_front());
                end
                last_word = resp_data;
                hs_cnt++;
                idle_chk = 1'b1;
            end
            prev_en    = puf_en;
            prev_prst  = puf_reset;
            prev_valid = resp_valid;
            prev_busy  = busy;
            prev_data  = resp_data;
            prev_chal  = puf_challenge;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] s);
        seed  = s;
        start = 1'b1;
        exp_q.push_back(model_word(s));
        for (int i = 0; i < RB; i++) chal_q.push_back(s + 8'(i));
        start_q.push_back(cyc);
        tick();
        start = 1'b0;
        seed  = 8'($urandom);   // must not affect the run in flight
    endtask

    task automatic wait_hs(input int budget, input bit rand_ready);
        int old = hs_cnt;
        int n   = 0;
        while (hs_cnt == old && n < budget) begin
            if (rand_ready) resp_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (hs_cnt == old) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic randomize_table();
        for (int i = 0; i < 256; i++) tbl[i] = 1'($urandom);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n;
        reset      = 1'b1;
        start      = 1'b0;
        seed       = 8'h00;
        resp_ready = 1'b0;
        randomize_table();
        repeat (3) tick();

        // Reset state
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_puf_en", 32'(puf_en), 32'd0);
        check("rst_puf_reset", 32'(puf_reset), 32'd1);
        check("rst_challenge", 32'(puf_challenge), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Directed single run: seed 3C, responses 1,0,1,1
        tbl[8'h3C] = 1'b1;
        tbl[8'h3D] = 1'b0;
        tbl[8'h3E] = 1'b1;
        tbl[8'h3F] = 1'b1;
        resp_ready = 1'b1;
        start_run(8'h3C);
        wait_hs(LAT + 10, 1'b0);
        check("directed_word_1101", 32'(last_word), 32'(4'b1101));
        repeat (3) tick();

        // Wrap across 8'hFF
        start_run(8'hFE);
        wait_hs(LAT + 10, 1'b0);
        repeat (2) tick();

        // Backpressure in DONE with start pulses
        resp_ready = 1'b0;
        start_run(8'($urandom));
        n = 0;
        while (!resp_valid && n < LAT + 10) begin
            tick();
            n++;
        end
        check("bp_valid_reached", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            start = (i % 3 == 0);
            seed  = 8'($urandom);
            tick();
            check("bp_valid_held", 32'(resp_valid), 32'd1);
            check("bp_busy_held", 32'(busy), 32'd1);
        end
        start      = 1'b0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("bp_accepted", 32'(resp_valid), 32'd0);
        tick();
        check("bp_start_ignored", 32'(busy), 32'd0);

        // Reset during MEASURE of bit 2 (cycles 30..37 after start)
        randomize_table();
        resp_ready = 1'b1;
        start_run(8'($urandom));
        repeat (31) tick();
        check("pre_abort_measuring", 32'({puf_en, puf_reset}), 32'(2'b10));
        reset = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_puf_en", 32'(puf_en), 32'd0);
        check("abort_puf_reset", 32'(puf_reset), 32'd1);
        check("abort_resp_data", 32'(resp_data), 32'd0);
        check("abort_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        tick();
        start_run(8'($urandom));
        wait_hs(LAT + 10, 1'b0);

        // Back-to-back with resp_ready tied high
        tick();
        start_run(8'($urandom));
        wait_hs(LAT + 10, 1'b0);
        start_run(8'($urandom));
        wait_hs(LAT + 10, 1'b0);

        // Randomised runs with random backpressure
        for (int r = 0; r < 4; r++) begin
            tick();
            randomize_table();
            repeat ($urandom_range(0, 3)) tick();
            start_run(8'($urandom));
            wait_hs(LAT + 200, 1'b1);
            resp_ready = 1'b0;
        end
        repeat (3) tick();

        check("all_words_consumed", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
